writeback: RTL

Final pipeline stage; consumes the memory stage's output bundle. Commits results to the 32-entry integer register file and serves the decode stage's two read ports with same-cycle write bypass. Converts a retiring exception into a one-cycle pipeline flush with a trap redirect. Maintains the cycle and retired-instruction counters.

---
 rtl/writeback_if.sv | 42 ++++
 rtl/writeback.sv | 127 ++++++++++++
 2 files changed

// File: rtl/writeback_if.sv
// rtl/writeback_if.sv - memory-stage bundle, decode read ports and trap/counter outputs of writeback
interface writeback_if #(
    parameter int XLEN = 32,
    parameter int EX_W = 4
);
    logic [XLEN-1:0] pc_in;
    logic            nop_instr_in;
    logic [XLEN-1:0] result_in;
    logic [4:0]      rd_addr_in;
    logic            pipeline_in_valid;
    logic [EX_W-1:0] exception_in;
    logic            exception_in_valid;
    logic            stall_in;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            flush_out;
    logic [XLEN-1:0] trap_pc_out;
    logic [XLEN-1:0] epc_out;
    logic [EX_W-1:0] cause_out;
    logic [63:0]     cycle_out;
    logic [63:0]     instret_out;

    modport master (
        output pc_in, nop_instr_in, result_in, rd_addr_in, pipeline_in_valid,
        output exception_in, exception_in_valid, stall_in,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data,
        input  flush_out, trap_pc_out, epc_out, cause_out, cycle_out, instret_out
    );

    modport slave (
        input  pc_in, nop_instr_in, result_in, rd_addr_in, pipeline_in_valid,
        input  exception_in, exception_in_valid, stall_in,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data,
        output flush_out, trap_pc_out, epc_out, cause_out, cycle_out, instret_out
    );
endinterface

// File: rtl/writeback.sv
// rtl/writeback.sv - final pipeline stage: register file commit, bypassed reads, trap flush, counters
module writeback #(
    parameter int               XLEN     = 32,
    parameter int               EX_W     = 4,
    parameter logic [XLEN-1:0]  TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    writeback_if.slave  wb
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [XLEN-1:0] rf [0:31];
    logic [XLEN-1:0] epc_q;
    logic [EX_W-1:0] cause_q;
    logic [63:0]     cycle_q;
    logic [63:0]     instret_q;

    logic accept;
    logic retire;
    logic we;
    logic take_exc;

    // Everything presented while stalled or flushing is dropped without side effects.
    assign accept   = wb.pipeline_in_valid && !wb.stall_in && (state == IDLE);
    assign retire   = accept && !wb.exception_in_valid && !wb.nop_instr_in;
    assign we       = retire && (wb.rd_addr_in != 5'd0);
    assign take_exc = accept && wb.exception_in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        wb.flush_out   = 1'b0;
        wb.trap_pc_out = '0;
        unique case (state)
            IDLE: begin
                if (take_exc) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                wb.flush_out   = 1'b1;
                wb.trap_pc_out = TRAP_VEC;
                next_state     = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[wb.rd_addr_in] <= wb.result_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q   <= '0;
            cause_q <= '0;
        end else if (take_exc) begin
            epc_q   <= wb.pc_in;
            cause_q <= wb.exception_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    // A value being committed this cycle is forwarded ahead of the array.
    always_comb begin
        wb.rs1_data = '0;
        if (wb.rs1_addr != 5'd0) begin
            if (we && (wb.rd_addr_in == wb.rs1_addr)) begin
                wb.rs1_data = wb.result_in;
            end else begin
                wb.rs1_data = rf[wb.rs1_addr];
            end
        end
    end

    always_comb begin
        wb.rs2_data = '0;
        if (wb.rs2_addr != 5'd0) begin
            if (we && (wb.rd_addr_in == wb.rs2_addr)) begin
                wb.rs2_data = wb.result_in;
            end else begin
                wb.rs2_data = rf[wb.rs2_addr];
            end
        end
    end

    assign wb.epc_out     = epc_q;
    assign wb.cause_out   = cause_q;
    assign wb.cycle_out   = cycle_q;
    assign wb.instret_out = instret_q;

endmodule
